// File: rtl/fifo_pkt_reader.sv
// rtl/fifo_pkt_reader.sv - packet FIFO read-side consumer with framing check and skid buffer
//
// Pops framed words {sop, eop, mod, data} from a synchronous-read FIFO
// (1-cycle read latency) and re-emits them on a valid/ready stream.
// Orphan words are dropped, a sop inside a packet is forwarded and flagged,
// and eop words accepted at the output are counted.
//
// Ports:
//   rclk, rrst      clock, asynchronous active-high reset
//   enable          allow new FIFO reads; words already read still drain
//   fifo_ren        FIFO read enable
//   fifo_rdata      FIFO word, valid the cycle after fifo_ren
//   fifo_rempty     FIFO empty
//   out_valid/out_ready/out_data/out_sop/out_eop/out_mod   output stream
//   err_orphan      1-cycle pulse, non-sop word outside a packet
//   err_sop_in_pkt  1-cycle pulse, sop inside a packet
//   pkt_count       eop words accepted at the output (wraps)

module fifo_pkt_reader #(
  parameter int DWIDTH    = 64,
  parameter int MOD_WIDTH = 3,
  parameter int CNT_WIDTH = 16
) (
  input  logic                          rclk,
  input  logic                          rrst,
  input  logic                          enable,
  output logic                          fifo_ren,
  input  logic [DWIDTH+MOD_WIDTH+1:0]   fifo_rdata,
  input  logic                          fifo_rempty,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DWIDTH-1:0]             out_data,
  output logic                          out_sop,
  output logic                          out_eop,
  output logic [MOD_WIDTH-1:0]          out_mod,
  output logic                          err_orphan,
  output logic                          err_sop_in_pkt,
  output logic [CNT_WIDTH-1:0]          pkt_count
);

  localparam int WW = DWIDTH + MOD_WIDTH + 2;

  typedef enum logic [1:0] {IDLE, IN_PKT, DROP} state_t;

  state_t          state;
  state_t          state_nxt;
  logic            inflight;
  logic [1:0]      occ;
  logic [1:0]      occ_after_pop;
  logic [2:0]      credit_used;
  logic [WW-1:0]   slot0;
  logic [WW-1:0]   slot1;
  logic            pop;
  logic            push;
  logic            orphan;
  logic            sop_in_pkt;
  logic            in_sop;
  logic            in_eop;

  assign in_sop = fifo_rdata[WW-1];
  assign in_eop = fifo_rdata[WW-2];

  // Output side always shows the buffer head.
  assign out_valid = (occ != 2'd0);
  assign out_data  = slot0[DWIDTH-1:0];
  assign out_sop   = slot0[WW-1];
  assign out_eop   = slot0[WW-2];
  assign out_mod   = slot0[WW-2] ? slot0[DWIDTH +: MOD_WIDTH] : '0;

  assign pop           = out_valid & out_ready;
  assign occ_after_pop = occ - {1'b0, pop};

  // Read credit: a read issued now lands two edges later, so buffered plus
  // in-flight words (less the one leaving this cycle) must stay below 2.
  assign credit_used = {1'b0, occ} + {2'b00, inflight};
  assign fifo_ren    = ~rrst & enable & ~fifo_rempty &
                       (credit_used < (3'd2 + {2'b00, pop}));

  // Framing FSM, advanced only on captured words.
  always_comb begin
    state_nxt  = state;
    push       = 1'b0;
    orphan     = 1'b0;
    sop_in_pkt = 1'b0;
    if (inflight) begin
      case (state)
        IDLE, DROP: begin
          if (in_sop) begin
            push      = 1'b1;
            state_nxt = in_eop ? IDLE : IN_PKT;
          end else begin
            // Only the first orphan of a run is reported; DROP stays quiet.
            orphan    = (state == IDLE);
            state_nxt = in_eop ? IDLE : DROP;
          end
        end
        IN_PKT: begin
          push       = 1'b1;
          sop_in_pkt = in_sop;
          state_nxt  = in_eop ? IDLE : IN_PKT;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      inflight       <= 1'b0;
      occ            <= 2'd0;
      slot0          <= '0;
      slot1          <= '0;
      err_orphan     <= 1'b0;
      err_sop_in_pkt <= 1'b0;
      pkt_count      <= '0;
    end else begin
      inflight       <= fifo_ren;
      err_orphan     <= orphan;
      err_sop_in_pkt <= sop_in_pkt;
      occ            <= occ_after_pop + {1'b0, push};
      if (pop) begin
        slot0 <= slot1;
      end
      // A push lands in the first free slot after this cycle's pop; it
      // overrides the shift above when the buffer drains to empty.
      if (push) begin
        if (occ_after_pop == 2'd0) begin
          slot0 <= fifo_rdata;
        end else begin
          slot1 <= fifo_rdata;
        end
      end
      if (pop && out_eop) begin
        pkt_count <= pkt_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// tb/tb_fifo_pkt_reader.sv - directed self-checking bench for fifo_pkt_reader

module tb_fifo_pkt_reader;

  localparam int DW = 64;
  localparam int MW = 3;
  localparam int WW = DW + MW + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          fifo_ren;
  logic [WW-1:0] fifo_rdata = '0;
  logic          fifo_rempty;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_sop;
  logic          out_eop;
  logic [MW-1:0] out_mod;
  logic          err_orphan;
  logic          err_sop_in_pkt;
  logic [15:0]   pkt_count;

  fifo_pkt_reader dut (
    .rclk(clk), .rrst(rst), .enable(enable),
    .fifo_ren(fifo_ren), .fifo_rdata(fifo_rdata), .fifo_rempty(fifo_rempty),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sop(out_sop), .out_eop(out_eop), .out_mod(out_mod),
    .err_orphan(err_orphan), .err_sop_in_pkt(err_sop_in_pkt),
    .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: synchronous read, data valid the cycle after fifo_ren.
  logic [WW-1:0] mem [1024];
  int wr = 0;
  int rd = 0;
  assign fifo_rempty = (wr == rd);
  always @(posedge clk) begin
    if (fifo_ren) begin
      fifo_rdata <= mem[rd[9:0]];
      rd <= rd + 1;
    end
  end

  // Output monitor, sampled on the falling edge.
  logic [DW-1:0] log_data [64];
  logic          log_sop  [64];
  logic          log_eop  [64];
  logic [MW-1:0] log_mod  [64];
  int n_out, n_orph, n_sip, n_ren, sip_cyc, stall_err, credit_err;
  logic chk_credit = 1'b0;
  logic prev_stall = 1'b0;
  logic [DW+MW+2:0] prev_vec;
  int outstanding;

  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall && ({out_valid, out_data, out_sop, out_eop, out_mod} !== prev_vec))
        stall_err++;
      prev_stall = out_valid && !out_ready;
      prev_vec   = {out_valid, out_data, out_sop, out_eop, out_mod};
      outstanding = n_ren - n_out;
      if (chk_credit && fifo_ren && (outstanding - ((out_valid && out_ready) ? 1 : 0) >= 2))
        credit_err++;
      if (out_valid && out_ready) begin
        if (n_out < 64) begin
          log_data[n_out] = out_data;
          log_sop[n_out]  = out_sop;
          log_eop[n_out]  = out_eop;
          log_mod[n_out]  = out_mod;
        end
        n_out++;
      end
      if (err_orphan) n_orph++;
      if (err_sop_in_pkt) begin
        n_sip++;
        sip_cyc = cyc;
      end
      if (fifo_ren) n_ren++;
    end else begin
      prev_stall = 1'b0;
    end
  end

  int vectors = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [WW-1:0] mk(input logic s, input logic e,
                                       input logic [MW-1:0] m, input logic [DW-1:0] d);
    return {s, e, m, d};
  endfunction

  task automatic push(input logic [WW-1:0] w);
    mem[wr[9:0]] = w;
    wr++;
  endtask

  task automatic clr();
    n_out = 0; n_orph = 0; n_sip = 0; n_ren = 0;
    sip_cyc = -1; stall_err = 0; credit_err = 0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int c0;

  initial begin
    rst = 1'b1; enable = 1'b0; out_ready = 1'b0;
    clr();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ren", fifo_ren, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_sop_eop_mod", {out_sop, out_eop, out_mod}, 0);
    chk("rst_err", {err_orphan, err_sop_in_pkt}, 0);
    chk("rst_cnt", pkt_count, 0);
    step(1);
    rst = 1'b0; enable = 1'b1; out_ready = 1'b1;
    clr();

    // Single 3-word packet.
    push(mk(1, 0, 0, 64'h1111));
    push(mk(0, 0, 0, 64'h2222));
    push(mk(0, 1, 5, 64'h3333));
    @(negedge clk); chk("t1_c0_ren", fifo_ren, 1); chk("t1_c0_vld", out_valid, 0);
    @(negedge clk); chk("t1_c1_ren", fifo_ren, 1); chk("t1_c1_vld", out_valid, 0);
    @(negedge clk); chk("t1_c2_ren", fifo_ren, 1); chk("t1_c2_vld", out_valid, 1);
    chk("t1_w0", {out_sop, out_eop, out_data}, {2'b10, 64'h1111});
    @(negedge clk); chk("t1_c3_ren", fifo_ren, 0); chk("t1_c3_vld", out_valid, 1);
    chk("t1_w1", {out_sop, out_eop, out_data}, {2'b00, 64'h2222});
    @(negedge clk); chk("t1_c4_vld", out_valid, 1);
    chk("t1_w2", {out_sop, out_eop, out_mod, out_data}, {2'b01, 3'd5, 64'h3333});
    @(negedge clk); chk("t1_c5_vld", out_valid, 0); chk("t1_cnt", pkt_count, 1);
    step(1);

    // 8-word packet under 1,0,0,1 backpressure.
    clr();
    chk_credit = 1'b1;
    for (int i = 0; i < 8; i++)
      push(mk(i == 0, i == 7, (i == 7) ? 3'd2 : 3'd0, 64'hB000 + 64'(i)));
    for (int i = 0; i < 40; i++) begin
      out_ready = (i % 4 == 0) || (i % 4 == 3);
      step(1);
    end
    out_ready = 1'b1;
    chk_credit = 1'b0;
    chk("t2_nout", n_out, 8);
    for (int i = 0; i < 8; i++)
      chk("t2_data", log_data[i], 64'hB000 + 64'(i));
    chk("t2_sop0", log_sop[0], 1);
    chk("t2_eop7_mod", {log_eop[7], log_mod[7]}, {1'b1, 3'd2});
    chk("t2_stall", stall_err, 0);
    chk("t2_credit", credit_err, 0);
    chk("t2_cnt", pkt_count, 2);

    // Orphan words before a single-word packet.
    clr();
    push(mk(0, 0, 0, 64'hC1));
    push(mk(0, 1, 4, 64'hC2));
    push(mk(1, 1, 2, 64'hC3));
    step(10);
    chk("t3_orph", n_orph, 1);
    chk("t3_sip", n_sip, 0);
    chk("t3_nout", n_out, 1);
    chk("t3_word", {log_sop[0], log_eop[0], log_mod[0], log_data[0]}, {2'b11, 3'd2, 64'hC3});
    chk("t3_cnt", pkt_count, 3);

    // SOP inside a packet.
    clr();
    push(mk(1, 0, 0, 64'hD0));
    push(mk(0, 0, 0, 64'hD1));
    push(mk(1, 0, 0, 64'hD2));
    push(mk(0, 1, 7, 64'hD3));
    c0 = cyc;
    step(10);
    chk("t4_nout", n_out, 4);
    for (int i = 0; i < 4; i++)
      chk("t4_data", log_data[i], 64'hD0 + 64'(i));
    chk("t4_sop", {log_sop[0], log_sop[1], log_sop[2], log_sop[3]}, 4'b1010);
    chk("t4_sip", n_sip, 1);
    chk("t4_sip_cyc", sip_cyc, c0 + 4);
    chk("t4_orph", n_orph, 0);
    chk("t4_cnt", pkt_count, 4);

    // Empty FIFO: no reads.
    clr();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk("t5_empty_ren", fifo_ren, 0);
    end
    step(1);

    // Enable dropped mid-packet with two words buffered.
    out_ready = 1'b0;
    push(mk(1, 0, 0, 64'hE0));
    for (int i = 1; i < 6; i++) push(mk(0, 0, 0, 64'hE0 + 64'(i)));
    @(negedge clk); chk("t6_ren0", fifo_ren, 1);
    @(negedge clk); chk("t6_ren1", fifo_ren, 1);
    @(negedge clk); chk("t6_ren_full", fifo_ren, 0);
    step(1);
    enable = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); chk("t6_ren_dis", fifo_ren, 0);
    end
    chk("t6_nout", n_out, 2);
    chk("t6_w0", log_data[0], 64'hE0);
    chk("t6_w1", log_data[1], 64'hE1);
    chk("t6_vld", out_valid, 0);
    step(1);

    // Reset mid-packet.
    enable = 1'b1;
    @(negedge clk); chk("t7_cnt_pre", pkt_count, 4);
    step(2);
    chk("t7_vld_pre", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("t7_rst_vld", out_valid, 0);
    chk("t7_rst_data", out_data, 0);
    chk("t7_rst_ren", fifo_ren, 0);
    chk("t7_rst_cnt", pkt_count, 0);
    step(1);
    rst = 1'b0;
    rd = wr;
    clr();
    push(mk(1, 0, 0, 64'hF0));
    push(mk(0, 1, 3, 64'hF1));
    step(8);
    chk("t7_nout", n_out, 2);
    chk("t7_w0", {log_sop[0], log_eop[0], log_data[0]}, {2'b10, 64'hF0});
    chk("t7_w1", {log_sop[1], log_eop[1], log_mod[1], log_data[1]}, {2'b01, 3'd3, 64'hF1});
    chk("t7_cnt", pkt_count, 1);

    // Counter wrap.
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    clr();
    for (int i = 0; i < 65535; i++) begin
      push(mk(1, 1, 0, 64'(i)));
      step(1);
    end
    step(6);
    chk("t8_cnt_max", pkt_count, 16'hFFFF);
    push(mk(1, 1, 1, 64'h5A5A));
    step(6);
    chk("t8_cnt_wrap", pkt_count, 0);
    chk("t8_nout", n_out, 65536);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
